bcd_adder_seq: RTL and testbench

Parametrised multi-digit packed-BCD adder/subtractor. It is the sequential successor to the single-digit BCD adder.
- Processes one decimal digit per clock, least-significant digit first, under a start/ready/done handshake.
- Sits between operand registers and display/accumulator logic in the decimal-arithmetic datapath.

---
 rtl/bcd_adder_seq.sv | 138 +++++++++++++
 tb/tb_bcd_adder_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_seq.sv
// Sequential packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Optional input checking via `define BCD_INPUT_CHECK_EN (adds err output).
module bcd_adder_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
`ifdef BCD_INPUT_CHECK_EN
    output logic                  err,
`endif
    output logic                  cout
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub_q;
    logic          carry;

    logic [3:0]    a_i;
    logic [3:0]    b_i;
    logic [3:0]    bd;
    logic [4:0]    t;
    logic          gt9;
    logic [3:0]    digit;
    logic          last;

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);
    assign last  = (idx == IW'(DIGITS - 1));

    // Digit select is a decoded mux so every part-select index is constant.
    always_comb begin
        a_i = 4'd0;
        b_i = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_i = a_q[4*i +: 4];
                b_i = b_q[4*i +: 4];
            end
        end
    end

    // Subtraction adds the 9's complement of b; the initial carry of ~cin
    // completes the 10's complement and folds in the borrow.
    always_comb begin
        bd    = sub_q ? (4'd9 - b_i) : b_i;
        t     = {1'b0, a_i} + {1'b0, bd} + {4'd0, carry};
        gt9   = (t > 5'd9);
        digit = gt9 ? (t[3:0] + 4'd6) : t[3:0];
    end

`ifdef BCD_INPUT_CHECK_EN
    logic bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= bad;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) begin
                            sum[4*i +: 4] <= digit;
                        end
                    end
                    carry <= gt9;
                    if (last) begin
                        cout  <= gt9;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Scoreboard bench for bcd_adder_seq: decimal reference model, random + directed ops.
// Define BCD_INPUT_CHECK_EN to also exercise the err output.
module tb_bcd_adder_seq;

    localparam int D = 4;
    localparam int W = 4 * D;

    typedef struct {
        bit           care;
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BCD_INPUT_CHECK_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_adder_seq #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .sum   (sum),
`ifdef BCD_INPUT_CHECK_EN
        .err   (err),
`endif
        .cout  (cout)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint b2i(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] i2b(input longint n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Decimal reference: plain integer arithmetic modulo 10^D.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic c);
        exp_t e;
        longint m = 1;
        longint v;
        for (int i = 0; i < D; i++) m = m * 10;
        e.care = 1'b1;
        if (!s) begin
            v   = b2i(x) + b2i(y) + longint'(c);
            e.c = (v >= m);
            e.s = i2b(v % m);
        end else begin
            v   = b2i(x) - b2i(y) - longint'(c);
            e.c = (v >= 0);
            if (v < 0) v = v + m;
            e.s = i2b(v);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(9));
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.care) begin
                    chk("sb_sum", 64'(sum), 64'(e.s));
                    chk("sb_cout", 64'(cout), 64'(e.c));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic c,
                         input bit care, input bit poke, input bit exp_err);
        exp_t e;
        int lat;
        int d0;
        wait_ready();
        e = model(x, y, s, c);
        e.care = care;
        sb.push_back(e);
        d0 = done_cnt;
        start = 1'b1;
        a = x;
        b = y;
        sub = s;
        cin = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        sub = $urandom;
        cin = $urandom;
        chk("accept_ready", 64'(ready), 64'd0);
        chk("accept_clear", 64'({cout, sum}), 64'd0);
`ifdef BCD_INPUT_CHECK_EN
        chk("err_accept", 64'(err), 64'(exp_err));
`endif
        lat = 1;
        while (done !== 1'b1 && lat < 50) begin
            if (poke && lat == 1) begin
                start = 1'b1;
                a = 16'h1111;
                b = 16'h2222;
                sub = 1'b0;
                cin = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(D + 1));
        if (care) begin
            chk("done_sum", 64'(sum), 64'(e.s));
            chk("done_cout", 64'(cout), 64'(e.c));
        end
`ifdef BCD_INPUT_CHECK_EN
        chk("err_hold", 64'(err), 64'(exp_err));
`endif
        @(posedge clk);
        #1;
        chk("ready_after", 64'({ready, done}), 64'b10);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        if (care) chk("hold_sum", 64'({cout, sum}), 64'({e.c, e.s}));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        cin = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({ready, done, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));
`ifdef BCD_INPUT_CHECK_EN
        chk("reset_err", 64'(err), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h0006, 16'h0009, 1'b0, 1'b0, 1, 0, 0);
        do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1, 0, 0);
        do_op(16'h9999, 16'h9999, 1'b0, 1'b1, 1, 0, 0);
        do_op(16'h0050, 16'h0023, 1'b1, 1'b0, 1, 0, 0);
        do_op(16'h0023, 16'h0050, 1'b1, 1'b0, 1, 0, 0);
        do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1, 0, 0);
        do_op(16'h0003, 16'h0003, 1'b0, 1'b1, 1, 1, 0);

        // Abort in the second CALC cycle: no done, outputs back to reset.
        wait_ready();
        d0 = done_cnt;
        start = 1'b1;
        a = 16'h1234;
        b = 16'h1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_state", 64'({ready, done, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        do_op(16'h0008, 16'h0002, 1'b0, 1'b0, 1, 0, 0);

`ifdef BCD_INPUT_CHECK_EN
        do_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 0, 0, 1);
        chk("err_held_idle", 64'(err), 64'd1);
        do_op(16'h0004, 16'h0005, 1'b0, 1'b0, 1, 0, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            do_op(rnd_bcd(), rnd_bcd(), 1'($urandom), 1'($urandom), 1, 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
